// File: rtl/chroma_decimator.sv
// 4:4:4 -> 4:2:2 chroma decimator: 11-tap half-band FIR over U/V, one shared multiplier, packed SRAM writes.
// Define DECIM_SATURATE_EN to clip filter results to [0,255]; otherwise the low 8 bits are kept. LINE_WIDTH must be >= 8.
module chroma_decimator #(
    parameter int          LINE_WIDTH = 320,
    parameter int          NUM_LINES  = 240,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_U,
    input  logic [7:0]  in_V,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [17:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        done
);
    localparam int CW = $clog2(LINE_WIDTH + 1);
    localparam int LW = $clog2(NUM_LINES + 1);
    localparam logic [CW-1:0] LAST_PIX  = CW'(LINE_WIDTH - 1);
    localparam logic [CW-1:0] LAST_K    = CW'(LINE_WIDTH / 2 - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [7:0]         win_u_q [11];
    logic [7:0]         win_u_d [11];
    logic [7:0]         win_v_q [11];
    logic [7:0]         win_v_d [11];
    logic [7:0]         sh_u [10];
    logic [7:0]         sh_v [10];
    logic [CW-1:0]      in_cnt_q, in_cnt_d;
    logic [CW-1:0]      k_q, k_d;
    logic [LW-1:0]      line_q, line_d;
    logic [3:0]         step_q, step_d;
    logic signed [31:0] acc_q, acc_d;
    logic [7:0]         u_even_q, u_even_d, u_odd_q, u_odd_d, v_even_q, v_even_d;
    logic               buf_full_q, buf_full_d, buf_phase_q, buf_phase_d;
    logic [15:0]        buf_u_q, buf_u_d, buf_v_q, buf_v_d;
    logic [17:0]        n_q, n_d;
    logic               drain_q, drain_d;
    logic               done_q, done_d;

    logic [7:0]         tap_a, tap_b;
    logic signed [31:0] coef, pair_sum, prod, acc_sum;
    logic [7:0]         res8;
    logic               fill, push, mac_go;
    logic [7:0]         push_u, push_v;

    // Window slot i holds x[2k-5+i]; a push drops slot 0 and appends at slot 10.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_shift
            assign sh_u[gi] = win_u_q[gi + 1];
            assign sh_v[gi] = win_v_q[gi + 1];
        end
    endgenerate

    // Steps 0-3 accumulate U, steps 4-7 accumulate V: centre, +-1, +-3, +-5.
    always_comb begin
        tap_b = 8'd0;
        case (step_q[1:0])
            2'd0: begin
                tap_a = step_q[2] ? win_v_q[5] : win_u_q[5];
                coef  = 32'sd256;
            end
            2'd1: begin
                tap_a = step_q[2] ? win_v_q[4] : win_u_q[4];
                tap_b = step_q[2] ? win_v_q[6] : win_u_q[6];
                coef  = 32'sd159;
            end
            2'd2: begin
                tap_a = step_q[2] ? win_v_q[2] : win_u_q[2];
                tap_b = step_q[2] ? win_v_q[8] : win_u_q[8];
                coef  = -32'sd52;
            end
            default: begin
                tap_a = step_q[2] ? win_v_q[0] : win_u_q[0];
                tap_b = step_q[2] ? win_v_q[10] : win_u_q[10];
                coef  = 32'sd21;
            end
        endcase
        pair_sum = $signed({23'd0, {1'b0, tap_a} + {1'b0, tap_b}});
        prod     = pair_sum * coef;
        acc_sum  = ((step_q[1:0] == 2'd0) ? 32'sd256 : acc_q) + prod;
    end

`ifdef DECIM_SATURATE_EN
    logic signed [31:0] shifted;
    always_comb begin
        shifted = acc_sum >>> 9;
        if (shifted < 32'sd0)
            res8 = 8'd0;
        else if (shifted > 32'sd255)
            res8 = 8'd255;
        else
            res8 = shifted[7:0];
    end
`else
    assign res8 = acc_sum[16:9];
`endif

    // Completing an odd output needs an empty pair buffer; otherwise the MAC holds at step 7.
    assign mac_go = !(step_q == 4'd7 && k_q[0] && buf_full_q);

    always_comb begin
        state_d     = state_q;
        win_u_d     = win_u_q;
        win_v_d     = win_v_q;
        in_cnt_d    = in_cnt_q;
        k_d         = k_q;
        line_d      = line_q;
        step_d      = step_q;
        acc_d       = acc_q;
        u_even_d    = u_even_q;
        u_odd_d     = u_odd_q;
        v_even_d    = v_even_q;
        buf_full_d  = buf_full_q;
        buf_phase_d = buf_phase_q;
        buf_u_d     = buf_u_q;
        buf_v_d     = buf_v_q;
        n_d         = n_q;
        drain_d     = drain_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        fill        = 1'b0;
        push        = 1'b0;
        push_u      = in_U;
        push_v      = in_V;

        if (buf_full_q && wr_ready) begin
            if (!buf_phase_q) begin
                buf_phase_d = 1'b1;
            end else begin
                buf_full_d  = 1'b0;
                buf_phase_d = 1'b0;
                n_d         = n_q + 18'd1;
                if (drain_q) begin
                    done_d  = 1'b1;
                    drain_d = 1'b0;
                    state_d = IDLE;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = LOAD;
                    n_d      = 18'd0;
                    line_d   = '0;
                    in_cnt_d = '0;
                    step_d   = 4'd0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_cnt_q == '0)
                        fill = 1'b1;
                    else
                        push = 1'b1;
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_cnt_q == CW'(5)) begin
                        state_d = RUN;
                        step_d  = 4'd0;
                        k_d     = '0;
                    end
                end
            end
            default: begin
                if (drain_q) begin
                    // waiting for the final V word to be accepted
                end else if (step_q < 4'd8) begin
                    if (mac_go) begin
                        acc_d  = acc_sum;
                        step_d = step_q + 4'd1;
                        if (step_q == 4'd3) begin
                            if (k_q[0])
                                u_odd_d = res8;
                            else
                                u_even_d = res8;
                        end
                        if (step_q == 4'd7) begin
                            k_d = k_q + CW'(1);
                            if (k_q[0]) begin
                                buf_full_d  = 1'b1;
                                buf_phase_d = 1'b0;
                                buf_u_d     = {u_even_q, u_odd_q};
                                buf_v_d     = {v_even_q, res8};
                            end else begin
                                v_even_d = res8;
                            end
                            if (k_q == LAST_K) begin
                                step_d = 4'd0;
                                if (line_q == LAST_LINE) begin
                                    drain_d = 1'b1;
                                end else begin
                                    state_d  = LOAD;
                                    in_cnt_d = '0;
                                    line_d   = line_q + LW'(1);
                                end
                            end
                        end
                    end
                end else if (state_q == FLUSH) begin
                    push   = 1'b1;
                    push_u = win_u_q[10];
                    push_v = win_v_q[10];
                    step_d = (step_q == 4'd9) ? 4'd0 : step_q + 4'd1;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        push     = 1'b1;
                        in_cnt_d = in_cnt_q + CW'(1);
                        step_d   = (step_q == 4'd9) ? 4'd0 : step_q + 4'd1;
                        if (in_cnt_q == LAST_PIX)
                            state_d = FLUSH;
                    end
                end
            end
        endcase

        if (fill) begin
            for (int i = 0; i < 11; i++) begin
                win_u_d[i] = in_U;
                win_v_d[i] = in_V;
            end
        end else if (push) begin
            for (int i = 0; i < 10; i++) begin
                win_u_d[i] = sh_u[i];
                win_v_d[i] = sh_v[i];
            end
            win_u_d[10] = push_u;
            win_v_d[10] = push_v;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < 11; i++) begin
                win_u_q[i] <= 8'd0;
                win_v_q[i] <= 8'd0;
            end
            in_cnt_q    <= '0;
            k_q         <= '0;
            line_q      <= '0;
            step_q      <= 4'd0;
            acc_q       <= 32'sd0;
            u_even_q    <= 8'd0;
            u_odd_q     <= 8'd0;
            v_even_q    <= 8'd0;
            buf_full_q  <= 1'b0;
            buf_phase_q <= 1'b0;
            buf_u_q     <= 16'd0;
            buf_v_q     <= 16'd0;
            n_q         <= 18'd0;
            drain_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_u_q     <= win_u_d;
            win_v_q     <= win_v_d;
            in_cnt_q    <= in_cnt_d;
            k_q         <= k_d;
            line_q      <= line_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            u_even_q    <= u_even_d;
            u_odd_q     <= u_odd_d;
            v_even_q    <= v_even_d;
            buf_full_q  <= buf_full_d;
            buf_phase_q <= buf_phase_d;
            buf_u_q     <= buf_u_d;
            buf_v_q     <= buf_v_d;
            n_q         <= n_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
        end
    end

    assign wr_valid = buf_full_q;
    assign wr_addr  = !buf_full_q ? 18'd0 : (buf_phase_q ? V_BASE + n_q : U_BASE + n_q);
    assign wr_data  = !buf_full_q ? 16'd0 : (buf_phase_q ? buf_v_q : buf_u_q);
    assign done     = done_q;

endmodule

// File: tb/tb_chroma_decimator.sv
// Randomized bench for chroma_decimator against a per-pixel arithmetic model of the decimation filter.
module tb_chroma_decimator;
    localparam int          W      = 16;
    localparam int          L      = 3;
    localparam logic [17:0] UB     = 18'd38400;
    localparam logic [17:0] VB     = 18'd57600;
    localparam int          BUDGET = 5000;

    logic        clk = 1'b0;
    logic        reset, frame_start, in_valid, in_ready, wr_valid, wr_ready, done;
    logic [7:0]  in_U, in_V;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  pu [L*W];
    logic [7:0]  pv [L*W];
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    chroma_decimator #(.LINE_WIDTH(W), .NUM_LINES(L), .U_BASE(UB), .V_BASE(VB)) dut (
        .CLOCK_50_I (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_U       (in_U),
        .in_V       (in_V),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int px(input int line, input int j, input bit is_v);
        int jj;
        jj = (j < 0) ? 0 : ((j > W - 1) ? W - 1 : j);
        return is_v ? int'(pv[line*W + jj]) : int'(pu[line*W + jj]);
    endfunction

    function automatic logic [7:0] filt(input int line, input int k, input bit is_v);
        int c, acc, r;
        c   = 2 * k;
        acc = 256 * px(line, c, is_v)
            + 159 * (px(line, c - 1, is_v) + px(line, c + 1, is_v))
            - 52  * (px(line, c - 3, is_v) + px(line, c + 3, is_v))
            + 21  * (px(line, c - 5, is_v) + px(line, c + 5, is_v))
            + 256;
        r = acc >>> 9;
`ifdef DECIM_SATURATE_EN
        if (r < 0) r = 0;
        if (r > 255) r = 255;
`endif
        return 8'(r);
    endfunction

    task automatic build_expected();
        int n;
        exp_q.delete();
        for (int line = 0; line < L; line++) begin
            for (int m = 0; m < W / 4; m++) begin
                n = line * (W / 4) + m;
                exp_q.push_back({UB + 18'(n), filt(line, 2*m, 1'b0), filt(line, 2*m + 1, 1'b0)});
                exp_q.push_back({VB + 18'(n), filt(line, 2*m, 1'b1), filt(line, 2*m + 1, 1'b1)});
            end
        end
    endtask

    // rdy_mode: 0 = always ready, 1 = ready 1-in-3, 2 = ready 1-in-16 (forces MAC stalls).
    task automatic run_frame(input int rdy_mode, input bit gaps, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int done_cnt = 0;
        int tail = 0;
        bit in_fire = 1'b0;
        bit stop = 1'b0;
        bit aborted = 1'b0;
        build_expected();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (!stop) begin
            if (in_fire) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                wr_ready = 1'b0;
                @(negedge clk);
                check("rst_wr_valid", wr_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_wr_addr", wr_addr, 0);
                reset = 1'b0;
                exp_q.delete();
                aborted = 1'b1;
                stop = 1'b1;
            end else begin
                frame_start = (cyc == 30);
                if (idx < L * W) begin
                    in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                    in_U = pu[idx];
                    in_V = pv[idx];
                end else begin
                    in_valid = 1'b0;
                end
                in_fire = in_valid && in_ready;
                wr_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : (cyc % 16 == 0);
                if (wr_valid) begin
                    if (exp_q.size() == 0) begin
                        check("extra_write", wr_valid, 0);
                    end else begin
                        check("wr_addr", wr_addr, exp_q[0][33:16]);
                        check("wr_data", wr_data, exp_q[0][15:0]);
                        if (wr_ready) begin
                            $display("[TB] write addr=%05h data=%04h", wr_addr, wr_data);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_last", exp_q.size(), 0);
                end
                if (exp_q.size() == 0 && done_cnt > 0) tail++;
                if (tail >= 4) stop = 1'b1;
                cyc++;
                if (cyc >= BUDGET) begin
                    check("timeout_writes_left", exp_q.size(), 0);
                    stop = 1'b1;
                end
                @(negedge clk);
            end
        end
        frame_start = 1'b0;
        in_valid = 1'b0;
        if (!aborted) begin
            check("done_count", done_cnt, 1);
            check("end_in_ready", in_ready, 0);
            check("end_wr_valid", wr_valid, 0);
        end
    endtask

    task automatic fill_const(input logic [7:0] u, input logic [7:0] v);
        for (int i = 0; i < L * W; i++) begin
            pu[i] = u;
            pv[i] = v;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < L * W; i++) begin
            pu[i] = 8'($urandom);
            pv[i] = 8'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        in_valid = 1'b0;
        in_U = 8'd0;
        in_V = 8'd0;
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_wr_valid", wr_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_done", done, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        fill_const(8'd100, 8'd200);
        run_frame(0, 1'b0, -1);

        fill_const(8'd0, 8'd0);
        for (int line = 0; line < L; line++) pu[line*W + 9] = 8'd255;
        run_frame(0, 1'b0, -1);

        fill_const(8'd0, 8'd0);
        for (int line = 0; line < L; line++) begin
            pu[line*W] = 8'd50;
            pv[line*W + W - 1] = 8'd50;
        end
        run_frame(0, 1'b0, -1);

        fill_random();
        run_frame(1, 1'b0, -1);
        run_frame(2, 1'b0, -1);
        run_frame(0, 1'b1, -1);
        run_frame(2, 1'b1, -1);

        fill_random();
        run_frame(0, 1'b0, W + 7);
        @(negedge clk);
        check("post_abort_in_ready", in_ready, 0);
        run_frame(0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
